// File: rtl/mx_quant_pkg.sv
// mx_quant_pkg: shared definitions for the MX block quantizer.
//   state_t  - quantizer FSM states
//   shift_w  - bit width able to hold a shift amount in 0..in_width
package mx_quant_pkg;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_NORM    = 2'd1,
    S_OUT     = 2'd2
  } state_t;

  function automatic int shift_w(input int in_width);
    return $clog2(in_width) + 1;
  endfunction

endpackage

// File: rtl/mx_lod.sv
// mx_lod: combinational leading-one detector.
// Ports:
//   i_vec  - input vector
//   o_idx  - index of the most significant set bit (0 when i_vec is zero)
//   o_zero - 1 when i_vec has no set bit
module mx_lod #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_zero
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    o_idx  = '0;
    o_zero = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) begin
        o_idx  = IDX_W'(i);
        o_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mx_block_quantizer.sv
// mx_block_quantizer: collects K signed accumulator elements, finds the
// shared exponent from the OR of their magnitudes and emits K signed
// MAN_WIDTH+1 bit mantissas plus a shared (saturating) scale.
// Ports:
//   i_clk, i_rst_n      - clock, synchronous active-low reset
//   i_data, i_scale     - input element and its scale (scale taken from element 0)
//   i_valid / o_ready   - input handshake (o_ready only in COLLECT)
//   o_mant, o_scale     - block result, o_mant[0] is the first accepted element
//   o_valid / i_ready   - output handshake (o_valid only in OUT)
// Optional build macro: MX_QUANT_ROUND_EN enables round-half-away-from-zero
// mantissa rounding; without it mantissas are truncated toward zero.
module mx_block_quantizer
  import mx_quant_pkg::*;
#(
  parameter int IN_WIDTH    = 32,
  parameter int K           = 2,
  parameter int MAN_WIDTH   = 8,
  parameter int SCALE_WIDTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [IN_WIDTH-1:0]           i_data,
  input  logic [SCALE_WIDTH-1:0]        i_scale,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [K-1:0][MAN_WIDTH:0]     o_mant,
  output logic [SCALE_WIDTH-1:0]        o_scale,
  output logic                          o_valid,
  input  logic                          i_ready
);

  localparam int SHW  = shift_w(IN_WIDTH);
  localparam int IDXW = $clog2(IN_WIDTH);
  localparam int CNTW = $clog2(K);
  localparam int SUMW = ((SCALE_WIDTH > SHW) ? SCALE_WIDTH : SHW) + 1;

  state_t                       r_state;
  logic [CNTW-1:0]              r_cnt;
  logic [IN_WIDTH-1:0]          r_or;
  logic [IN_WIDTH-1:0]          r_mag [K];
  logic [K-1:0]                 r_neg;
  logic [SCALE_WIDTH-1:0]       r_scale_in;
  logic [K-1:0][MAN_WIDTH:0]    r_mant;
  logic [SCALE_WIDTH-1:0]       r_scale_out;
  logic                         r_valid;
  logic                         r_ready;

  logic [IN_WIDTH-1:0]          w_mag;
  logic [IDXW-1:0]              w_idx;
  logic                         w_zero;
  logic [SHW-1:0]               w_p1;
  logic [SHW-1:0]               w_shift;
  logic [SUMW-1:0]              w_ssum;
  logic [SCALE_WIDTH-1:0]       w_scale;
  logic [K-1:0][MAN_WIDTH:0]    w_mant;
  logic                         w_accept;

  assign o_ready  = r_ready;
  assign o_valid  = r_valid;
  assign o_mant   = r_mant;
  assign o_scale  = r_scale_out;
  assign w_accept = i_valid && r_ready;

  // Two's-complement negate in unsigned space: -2^(IN_WIDTH-1) maps to 2^(IN_WIDTH-1).
  assign w_mag = i_data[IN_WIDTH-1] ? (~i_data + IN_WIDTH'(1)) : i_data;

  mx_lod #(
    .WIDTH (IN_WIDTH),
    .IDX_W (IDXW)
  ) u_lod (
    .i_vec  (r_or),
    .o_idx  (w_idx),
    .o_zero (w_zero)
  );

  always_comb begin
    w_p1    = SHW'(w_idx) + SHW'(1);
    w_shift = '0;
    if (!w_zero && (int'(w_p1) > MAN_WIDTH)) begin
      w_shift = SHW'(int'(w_p1) - MAN_WIDTH);
    end
  end

  always_comb begin
    w_ssum = SUMW'(r_scale_in) + SUMW'(w_shift);
    if (w_ssum > SUMW'({SCALE_WIDTH{1'b1}})) begin
      w_scale = '1;
    end else begin
      w_scale = w_ssum[SCALE_WIDTH-1:0];
    end
  end

  always_comb begin
    logic [MAN_WIDTH-1:0] v_mag;
`ifdef MX_QUANT_ROUND_EN
    logic [IN_WIDTH:0]    v_ext;
`endif
    w_mant = '0;
    for (int unsigned i = 0; i < K; i++) begin
`ifdef MX_QUANT_ROUND_EN
      // Extra headroom bit: the rounding add can carry past the top magnitude bit.
      v_ext = {1'b0, r_mag[i]};
      if (w_shift != '0) begin
        v_ext = v_ext + ((IN_WIDTH+1)'(1) << (w_shift - SHW'(1)));
      end
      v_ext = v_ext >> w_shift;
      if (v_ext > (IN_WIDTH+1)'((1 << MAN_WIDTH) - 1)) begin
        v_mag = '1;
      end else begin
        v_mag = v_ext[MAN_WIDTH-1:0];
      end
`else
      v_mag = MAN_WIDTH'(r_mag[i] >> w_shift);
`endif
      w_mant[i] = r_neg[i] ? -{1'b0, v_mag} : {1'b0, v_mag};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_COLLECT;
      r_cnt       <= '0;
      r_or        <= '0;
      r_valid     <= 1'b0;
      r_ready     <= 1'b1;
      r_mant      <= '0;
      r_scale_out <= '0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_accept) begin
            r_mag[r_cnt] <= w_mag;
            r_neg[r_cnt] <= i_data[IN_WIDTH-1];
            // Element 0 restarts the OR so no explicit clear is needed between blocks.
            if (r_cnt == '0) begin
              r_scale_in <= i_scale;
              r_or       <= w_mag;
            end else begin
              r_or <= r_or | w_mag;
            end
            if (r_cnt == CNTW'(K - 1)) begin
              r_cnt   <= '0;
              r_ready <= 1'b0;
              r_state <= S_NORM;
            end else begin
              r_cnt <= r_cnt + CNTW'(1);
            end
          end
        end
        S_NORM: begin
          r_mant      <= w_mant;
          r_scale_out <= w_scale;
          r_valid     <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_COLLECT;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mx_block_quantizer.sv
// tb_mx_block_quantizer: directed, table-driven bench for mx_block_quantizer
// (K=2, MAN_WIDTH=8, IN_WIDTH=32, SCALE_WIDTH=8). Expectations follow the
// MX_QUANT_ROUND_EN build macro.
module tb_mx_block_quantizer;

  logic               clk;
  logic               rst_n;
  logic [31:0]        data;
  logic [7:0]         scale;
  logic               valid_in;
  logic               ready_out;
  logic [1:0][8:0]    mant;
  logic [7:0]         scale_out;
  logic               valid_out;
  logic               ready_in;

  int n_tests = 0;
  int n_fail  = 0;

  mx_block_quantizer #(
    .IN_WIDTH    (32),
    .K           (2),
    .MAN_WIDTH   (8),
    .SCALE_WIDTH (8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (data),
    .i_scale (scale),
    .i_valid (valid_in),
    .o_ready (ready_out),
    .o_mant  (mant),
    .o_scale (scale_out),
    .o_valid (valid_out),
    .i_ready (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int d0;
    int d1;
    int s0;
    int s1;
    int m0;
    int m1;
    int sc;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives a two-element block and checks latency (o_valid low one cycle
  // after the 2nd accept, high the next) and the block outputs.
  task automatic run_block(input string name, input int d0, input int d1,
                           input int s0, input int s1,
                           input int m0, input int m1, input int sc);
    @(negedge clk);
    check({name, ".ready"}, int'(ready_out), 1);
    valid_in = 1'b1; data = d0; scale = s0[7:0];
    @(negedge clk);
    data = d1; scale = s1[7:0];
    @(negedge clk);
    valid_in = 1'b0; data = '0; scale = '0;
    check({name, ".valid_norm"}, int'(valid_out), 0);
    @(negedge clk);
    check({name, ".valid"}, int'(valid_out), 1);
    check({name, ".m0"}, int'($signed(mant[0])), m0);
    check({name, ".m1"}, int'($signed(mant[1])), m1);
    check({name, ".scale"}, int'(scale_out), sc);
  endtask

  initial begin
    int hold_m0, hold_m1, hold_sc;

    vecs[0] = '{d0: 100,        d1: -3,   s0: 10,  s1: 99, m0: 100,  m1: -3,   sc: 10};
`ifdef MX_QUANT_ROUND_EN
    vecs[1] = '{d0: 1002,       d1: -22,  s0: 10,  s1: 0,  m0: 251,  m1: -6,   sc: 12};
    vecs[2] = '{d0: 511,        d1: 0,    s0: 10,  s1: 3,  m0: 255,  m1: 0,    sc: 11};
    vecs[5] = '{d0: 255,        d1: -256, s0: 5,   s1: 9,  m0: 128,  m1: -128, sc: 6};
`else
    vecs[1] = '{d0: 1002,       d1: -22,  s0: 10,  s1: 0,  m0: 250,  m1: -5,   sc: 12};
    vecs[2] = '{d0: 511,        d1: 0,    s0: 10,  s1: 3,  m0: 255,  m1: 0,    sc: 11};
    vecs[5] = '{d0: 255,        d1: -256, s0: 5,   s1: 9,  m0: 127,  m1: -128, sc: 6};
`endif
    vecs[3] = '{d0: 32'h80000000, d1: 0,  s0: 250, s1: 1,  m0: -128, m1: 0,    sc: 255};
    vecs[4] = '{d0: 0,          d1: 0,    s0: 7,   s1: 200, m0: 0,   m1: 0,    sc: 7};
    vecs[6] = '{d0: 255,        d1: -255, s0: 0,   s1: 1,  m0: 255,  m1: -255, sc: 0};

    rst_n = 1'b0; data = '0; scale = '0; valid_in = 1'b0; ready_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.valid", int'(valid_out), 0);
    check("rst.m0", int'($signed(mant[0])), 0);
    check("rst.m1", int'($signed(mant[1])), 0);
    check("rst.scale", int'(scale_out), 0);
    rst_n = 1'b1;
    check("rst.ready", int'(ready_out), 1);

    for (int i = 0; i < 7; i++) begin
      run_block($sformatf("vec%0d", i), vecs[i].d0, vecs[i].d1, vecs[i].s0,
                vecs[i].s1, vecs[i].m0, vecs[i].m1, vecs[i].sc);
    end

    // Backpressure: hold OUT for 5 cycles while junk elements are offered.
    @(negedge clk);
    ready_in = 1'b0;
    run_block("bp", vecs[1].d0, vecs[1].d1, vecs[1].s0, vecs[1].s1,
              vecs[1].m0, vecs[1].m1, vecs[1].sc);
    hold_m0 = vecs[1].m0; hold_m1 = vecs[1].m1; hold_sc = vecs[1].sc;
    valid_in = 1'b1; data = 77; scale = 99;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp.valid%0d", c), int'(valid_out), 1);
      check($sformatf("bp.ready%0d", c), int'(ready_out), 0);
      check($sformatf("bp.m0_%0d", c), int'($signed(mant[0])), hold_m0);
      check($sformatf("bp.m1_%0d", c), int'($signed(mant[1])), hold_m1);
      check($sformatf("bp.sc%0d", c), int'(scale_out), hold_sc);
    end
    ready_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; data = '0; scale = '0;
    check("bp.release_valid", int'(valid_out), 0);
    check("bp.release_ready", int'(ready_out), 1);
    // The junk element must not have been taken as element 0.
    run_block("bp.after", 6, -7, 3, 4, 6, -7, 3);

    // Reset after one accepted element discards it.
    @(negedge clk);
    valid_in = 1'b1; data = 50; scale = 20;
    @(negedge clk);
    valid_in = 1'b0; data = '0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid.valid", int'(valid_out), 0);
    check("rstmid.scale", int'(scale_out), 0);
    check("rstmid.ready", int'(ready_out), 1);
    run_block("rstmid.blk", 4, 5, 1, 2, 4, 5, 1);

    // Reset while a block is pending in OUT drops it.
    @(negedge clk);
    ready_in = 1'b0;
    run_block("rstout", 9, 8, 2, 2, 9, 8, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; ready_in = 1'b1;
    check("rstout.valid", int'(valid_out), 0);
    check("rstout.m0", int'($signed(mant[0])), 0);
    run_block("rstout.blk", -1, 2, 30, 31, -1, 2, 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mx_block_quantizer.md
MX_BLOCK_QUANTIZER -- requirements
Module: mx_block_quantizer

Interface
REQ-001 Parameter IN_WIDTH, default 32: width of the signed two's-complement accumulator input.
REQ-002 Parameter K, default 2: MX block size, in elements per shared scale; K >= 2, power of two.
REQ-003 Parameter MAN_WIDTH, default 8: output element mantissa width; element is MAN_WIDTH+1 bits signed.
REQ-004 Parameter SCALE_WIDTH, default 8: unsigned shared-scale width.
REQ-005 i_clk  in  1  sole clock; all state changes on rising edge.
REQ-006 i_rst_n  in  1  synchronous, active-low reset.
REQ-007 i_data  in  IN_WIDTH  signed accumulator element.
REQ-008 i_scale  in  SCALE_WIDTH  scale of i_data; sampled only with the first element of a block.
REQ-009 i_valid  in  1  input element valid.
REQ-010 o_ready  out  1  module accepts an element this cycle.
REQ-011 o_mant  out  [K] x (MAN_WIDTH+1)  signed block mantissas, element 0 = first accepted.
REQ-012 o_scale  out  SCALE_WIDTH  shared block scale.
REQ-013 o_valid  out  1  block output valid.
REQ-014 i_ready  in  1  downstream accepts the block.

Function
REQ-015 FSM states: COLLECT, NORM, OUT; an element is accepted on an edge where i_valid && o_ready.
REQ-016 o_ready SHALL be 1 only in COLLECT; o_valid SHALL be 1 only in OUT.
REQ-017 COLLECT: store accepted elements in order, count 0..K-1, latch i_scale on count 0, and accumulate the bitwise OR of element magnitudes; on the K-th accept go to NORM.
REQ-018 Magnitude = |i_data| as IN_WIDTH-bit unsigned; -2^(IN_WIDTH-1) gives 2^(IN_WIDTH-1) without overflow.
REQ-019 NORM (exactly one cycle): p = index of the MSB of the OR'd magnitude; shift = max(p+1-MAN_WIDTH, 0); all-zero block gives shift = 0.
REQ-020 Each mantissa = sign applied to (magnitude >> shift), truncated toward zero; result always fits MAN_WIDTH+1 signed.
REQ-021 o_scale = latched scale + shift, saturating at 2^SCALE_WIDTH-1.
REQ-022 Outputs are registered on leaving NORM; o_valid rises 2 edges after the K-th accept; throughput is one block per K+2 cycles minimum.
REQ-023 OUT: o_mant and o_scale stable while o_valid && !i_ready; on the edge with i_ready=1 go to COLLECT (no element accepted that cycle).
REQ-024 The value of i_scale on non-first elements SHALL be ignored.

Reset
REQ-025 i_rst_n=0 on an edge: state=COLLECT, count=0, OR accumulator=0, o_valid=0, o_mant all 0, o_scale=0; o_ready=1 from the next cycle.
REQ-026 Reset mid-block or mid-OUT discards partial or pending data; the next accepted element is element 0 of a new block.

Configuration
REQ-027 Macro MX_QUANT_ROUND_EN defined: when shift>0, add 2^(shift-1) to each magnitude before shifting (round half away from zero); a shifted magnitude of 2^MAN_WIDTH saturates to 2^MAN_WIDTH-1; scale is unchanged by rounding.
REQ-028 MX_QUANT_ROUND_EN undefined: pure truncation per REQ-020; no rounding adders synthesised.

Structure
REQ-029 Package mx_quant_pkg holds the FSM state enum and a shift-width constant function ($clog2(IN_WIDTH)+1).
REQ-030 One sub-module, mx_lod: combinational leading-one detector (IN_WIDTH in, index plus zero flag out); everything else in mx_block_quantizer.

Verification (K=2, MAN_WIDTH=8, IN_WIDTH=32, SCALE_WIDTH=8)
REQ-031 Elements 100, -3, scale 10 -> o_mant {100,-3}, o_scale 10, o_valid on the 2nd edge after the second accept.
REQ-032 Elements 1002, -22, scale 10 -> shift 2, scale 12; truncation {250,-5}; MX_QUANT_ROUND_EN {251,-6}; elements 511, 0 -> trunc {255,0}, round saturates {255,0}, scale 11.
REQ-033 Elements -2^31, 0, scale 250 -> o_mant {-128,0}, o_scale saturates to 255; elements 0, 0, scale 7 -> {0,0}, scale 7.
REQ-034 Backpressure: i_ready=0 for 5 cycles with o_valid=1 -> outputs constant, o_ready=0, extra i_valid ignored; i_ready=1 -> COLLECT next cycle.
REQ-035 Reset after one accepted element (value 50) -> o_valid=0; then elements 4, 5 -> block {4,5}, the value 50 never appears.
